// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier sequencer.
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_seq_state_t;

  localparam int DEF_WORD_LENGTH = 16;

  // Step counter is $clog2(W) bits; keep at least one bit for degenerate W=1.
  function automatic int step_cnt_w(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_add_sequencer_if.sv
// Operand/result handshake bundle between the operand registers and the sequencer.
interface mult_add_sequencer_if #(
  parameter int Word_Length = mult_seq_pkg::DEF_WORD_LENGTH
);
  logic                       start;
  logic [Word_Length-1:0]     Multiplicand;
  logic [Word_Length-1:0]     Multiplier;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic [2*Word_Length-1:0]   Product;

  modport master (
    output start, Multiplicand, Multiplier,
    input  ready, busy, done, Product
  );

  modport slave (
    input  start, Multiplicand, Multiplier,
    output ready, busy, done, Product
  );
endinterface

// File: rtl/seq_word_adder.sv
// Combinational wrap-around adder shared by every accumulate step of the sequencer.
module seq_word_adder #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  output logic [Width-1:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/mult_add_sequencer.sv
// Shift-and-add multiplier controller: one add/shift step per clock over a shared adder.
// Optional MULT_SEQ_EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module mult_add_sequencer
  import mult_seq_pkg::*;
#(
  parameter int Word_Length = DEF_WORD_LENGTH
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_add_sequencer_if.slave  bus
);
  localparam int W  = Word_Length;
  localparam int CW = step_cnt_w(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W-1);

  mult_seq_state_t r_state, w_state_nxt;

  logic [2*W-1:0] r_mcand_sh, r_acc, r_product;
  logic [2*W-1:0] w_addend, w_sum;
  logic [W-1:0]   r_mplier_sh, w_mplier_nxt;
  logic [CW-1:0]  r_step_cnt;
  logic           w_accept, w_last;

  assign w_mplier_nxt = r_mplier_sh >> 1;
  assign w_addend     = r_mplier_sh[0] ? r_mcand_sh : '0;

  seq_word_adder #(.Width(2*W)) u_adder (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

`ifdef MULT_SEQ_EARLY_TERM_EN
  // Nothing left to add once the shifted multiplier is empty.
  assign w_last = (r_step_cnt == LAST_STEP) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_step_cnt == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN:  if (w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand_sh  <= '0;
      r_mplier_sh <= '0;
      r_acc       <= '0;
      r_step_cnt  <= '0;
      r_product   <= '0;
    end else if (w_accept) begin
      r_mcand_sh  <= {{W{1'b0}}, bus.Multiplicand};
      r_mplier_sh <= bus.Multiplier;
      r_acc       <= '0;
      r_step_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_acc       <= w_sum;
      r_mcand_sh  <= r_mcand_sh << 1;
      r_mplier_sh <= w_mplier_nxt;
      r_step_cnt  <= r_step_cnt + CW'(1);
      // Capture the final sum on the edge into DONE so Product is valid with done.
      if (w_last) r_product <= w_sum;
    end
  end

  assign bus.ready   = (r_state == IDLE);
  assign bus.busy    = (r_state == RUN) || (r_state == DONE);
  assign bus.done    = (r_state == DONE);
  assign bus.Product = r_product;

endmodule

// File: tb/tb_mult_add_sequencer.sv
// Self-checking bench for mult_add_sequencer (W=16): vector table, random ops, corner sequences.
module tb_mult_add_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [2*W-1:0] last_prod;

  mult_add_sequencer_if #(.Word_Length(W)) bus ();

  mult_add_sequencer #(.Word_Length(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Cycles from the start-asserted cycle to the done cycle, both inclusive:
  // start cycle + RUN length + DONE cycle.
  function automatic int exp_cycles(input logic [W-1:0] b);
`ifdef MULT_SEQ_EARLY_TERM_EN
    int r = 1;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return r + 2;
`else
    return W + 2;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. Returns product seen with done,
  // the inclusive cycle count, and the state observed in the first RUN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                       output logic [2*W-1:0] prod, output int ncyc, output bit ok,
                       output logic rdy_run, output logic [2*W-1:0] prod_run);
    bus.start        = 1'b1;
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    step();
    bus.start = 1'b0;
    ncyc      = 2;
    ok        = 1'b0;
    rdy_run   = bus.ready;
    prod_run  = bus.Product;
    while (ncyc < 100) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (scramble) begin
        bus.Multiplicand = W'($urandom);
        bus.Multiplier   = W'($urandom);
      end
      step();
      ncyc++;
    end
    prod = bus.Product;
  endtask

  task automatic run_checked(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit scramble);
    logic [2*W-1:0] prod, prod_run, exp;
    int   ncyc;
    bit   ok;
    logic rdy_run;
    exp = (2*W)'(a) * (2*W)'(b);
    do_op(a, b, scramble, prod, ncyc, ok, rdy_run, prod_run);
    chk({tag, " ready low in RUN"}, 64'(rdy_run), 64'(0));
    chk({tag, " product held during RUN"}, 64'(prod_run), 64'(last_prod));
    chk({tag, " done seen"}, 64'(ok), 64'(1));
    chk({tag, " product"}, 64'(prod), 64'(exp));
    chk({tag, " latency"}, 64'(ncyc), 64'(exp_cycles(b)));
    step();
    chk({tag, " done one cycle"}, 64'(bus.done), 64'(0));
    chk({tag, " ready after done"}, 64'(bus.ready), 64'(1));
    chk({tag, " product held after done"}, 64'(bus.Product), 64'(exp));
    last_prod = exp;
  endtask

  initial begin
    vec_t vecs[8];
    int   ndone;
    logic [W-1:0] ra, rb;

    vecs[0] = '{16'd3,    16'd5,    32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0};
    vecs[3] = '{16'h0000, 16'h1234, 32'h0};
    vecs[4] = '{16'h1234, 16'h0001, 32'h0000_1234};
    vecs[5] = '{16'h1234, 16'h8000, 32'h091A_0000};
    vecs[6] = '{16'd100,  16'd200,  32'd20000};
    vecs[7] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};

    bus.start        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    reset            = 1'b1;
    last_prod        = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset ready", 64'(bus.ready), 64'(1));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset product", 64'(bus.Product), 64'(0));

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d table", i), 64'(vecs[i].exp),
          64'((2*W)'(vecs[i].a) * (2*W)'(vecs[i].b)));
      run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_checked($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Operands wiggled every RUN cycle must not disturb the latched pair.
    run_checked("scramble 100x200", 16'd100, 16'd200, 1'b1);

    // start held for 40 cycles: one op per (RUN length + 2) cycles.
    bus.start        = 1'b1;
    bus.Multiplicand = 16'd7;
    bus.Multiplier   = 16'd9;
    ndone            = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        ndone++;
        chk("held start product", 64'(bus.Product), 64'(63));
      end
      step();
    end
    bus.start = 1'b0;
    chk("held start op count", 64'(ndone), 64'(40 / exp_cycles(16'd9)));
    for (int i = 0; i < 100 && !bus.ready; i++) step();
    chk("held start drains", 64'(bus.ready), 64'(1));
    last_prod = 63;

    // Reset in the middle of RUN discards the operation.
    bus.start        = 1'b1;
    bus.Multiplicand = 16'h1234;
    bus.Multiplier   = 16'h00FF;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre-reset busy", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid-run reset ready", 64'(bus.ready), 64'(1));
    chk("mid-run reset busy", 64'(bus.busy), 64'(0));
    chk("mid-run reset product", 64'(bus.Product), 64'(0));
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done) ndone++;
      step();
    end
    chk("no done after reset", 64'(ndone), 64'(0));
    last_prod = '0;
    run_checked("post-reset 2x2", 16'd2, 16'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
